unidadecontrole_mc: RTL and testbench
=====================================

# unidadecontrole_mc

Parametrised multicycle control unit for the NRISC processor; successor to the single-cycle combinational decoder. Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB with a ready handshake to memory, generates all datapath strobes from the state register and the latched opcode, and counts retired instructions. It supports both halt instructions and external halt requests, and flags illegal opcodes. It sits between the instruction register/memory interface and the ULA/register-file datapath.

## Interface
- OPW, 3: opcode width; opcodes ≥ 8 are illegal.
- FUNCTW, 2: funct width, used only by opcode 110.
- ULAOPW, 3: ULAOp width, ≥ 3.
- CNTW, 16: width of the retired-instruction counter.
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- Opcode  in  OPW  instruction opcode; sampled in DECODE.
- Funct  in  FUNCTW  function field; sampled in DECODE.
- MemReady  in  1  memory completes the current read/write this cycle.
- Zero  in  1  ULA zero flag; sampled in EXEC.
- halt  in  1  external pause request.
- MemRead, MemWrite, Load, Beq, Slt, EscPC, EscIR, EscReg  out  1 each  datapath strobes.
- ULAsrc1, ULAsrc2  out  2 each  ULA operand mux selects.
- ULAOp  out  ULAOPW  ULA operation.
- Halted  out  1  processor is in HALTED.
- Illegal  out  1  one-cycle pulse: illegal opcode decoded.
- InstrCount  out  CNTW  retired instructions.

## Operation
- Opcodes: 000 add, 001 addi, 010 load, 011 store, 100 slt, 101 reset (rd ← 0), 110 system (Funct 00 or, 01 setbool, 10 reserved = illegal, 11 halt), 111 beq.
- ULAOp codes: ADD 000, SUB 001, SLT 010, OR 011, PASS 100, zero-extended to ULAOPW.
- ULAsrc1: 00 PC, 10 rs, 11 rd. ULAsrc2: 00 rt, 01 constant 1, 10 immediate, 11 zero.
- Outputs not listed for a state below are 0.
- IDLE: all outputs 0. Next state is FETCH.
- FETCH: MemRead=1, ULAsrc1=00, ULAsrc2=01, ULAOp=ADD. While MemReady=0, hold. When MemReady=1, EscIR=1 and EscPC=1 for that cycle, and the next state is DECODE.
- DECODE: latch Opcode and Funct; no strobes. Next state:
  - halt instruction → HALTED, sticky.
  - illegal opcode → Illegal=1, then retire as a no-op.
  - otherwise → EXEC.
- EXEC, per instruction:
  - add: ULAsrc 10/00, ULAOp ADD.
  - addi, load, store: ULAsrc 10/10, ULAOp ADD.
  - slt: ULAsrc 10/00, ULAOp SLT.
  - reset: ULAsrc 11/11, ULAOp PASS.
  - or: ULAsrc 11/01, ULAOp OR.
  - setbool: ULAsrc 11/11, ULAOp PASS.
  - beq: ULAsrc 10/00, ULAOp SUB, Beq=1, EscPC=Zero.
  - Next state: load/store → MEM; beq → retire; all others → WB.
- MEM: load drives MemRead=1; store drives MemWrite=1. Hold until MemReady=1. Then load → WB; store → retire.
- WB: EscReg=1. Load=1 for load; Slt=1 for slt.
- Retire: the last cycle of an instruction increments InstrCount. The counter wraps from 2^CNTW−1 to 0. Next state is HALTED (paused) if halt=1 in that cycle, else FETCH.
- HALTED: Halted=1.
  - Sticky (entered by the halt instruction): left only by reset.
  - Paused (entered by the halt input): returns to FETCH the cycle after halt is sampled 0.

## Timing
- All outputs are combinational from the state register and the latched opcode/funct, gated to 0 while reset=1, so no write strobe leaks in the reset cycle.
- At the edge where reset=1: state → IDLE, InstrCount → 0, latches → 0, sticky flag → 0.
- After reset: first FETCH is the second cycle after reset deasserts.
- Latencies with MemReady tied high:
  - beq: 3 cycles.
  - add, addi, slt, or, setbool, reset, store: 4 cycles.
  - load: 5 cycles.
  - illegal: 2 cycles.
  - halt instruction: 2 cycles to Halted=1.
- Each MemReady=0 cycle in FETCH or MEM adds exactly one cycle.
- halt is sampled only at retire and in paused HALTED. A pulse at any other time is ignored.
- A halt instruction does not increment InstrCount.
- Reset mid-MEM aborts the access; MemWrite is 0 in the reset cycle.

## Structure
- Package nrisc_pkg holds: opcode and funct constants, ULAOp codes, ULAsrc encodings, and the state enum (IDLE, FETCH, DECODE, EXEC, MEM, WB, HALTED).
- Sub-module contador_instrucoes: CNTW-bit counter with synchronous clear and enable.

## Test plan
- add 000, MemReady=1: EscIR/EscPC in cycle 1; EscReg in cycle 4; InstrCount 0→1.
- load 010, MemReady low for 2 cycles in MEM: MemRead held 3 cycles; WB shows Load=1, EscReg=1; total 7 cycles.
- beq 111 with Zero=1, then Zero=0: EscPC=1 in EXEC for the first, 0 for the second; Beq=1 both times; 3 cycles each.
- Opcode 110 Funct 11: Halted=1 from cycle 3 and stays with halt toggling; reset returns to IDLE with InstrCount=0.
- halt=1 at retire of an addi: Halted=1. Drop halt: FETCH the next cycle. Opcode 110 Funct 10: Illegal pulse 1 cycle, count +1.
- CNTW=4, 16 add instructions: InstrCount wraps 15→0. Reset asserted during store MEM: MemWrite=0 that cycle.

Source files
------------

// File: rtl/unidadecontrole_mc_pkg.sv
// NRISC multicycle control: shared opcode/funct constants, ULA encodings,
// FSM states and the instruction classifier used by the control unit.
package nrisc_pkg;

   localparam logic [2:0] OP_ADD    = 3'b000;
   localparam logic [2:0] OP_ADDI   = 3'b001;
   localparam logic [2:0] OP_LOAD   = 3'b010;
   localparam logic [2:0] OP_STORE  = 3'b011;
   localparam logic [2:0] OP_SLT    = 3'b100;
   localparam logic [2:0] OP_RESET  = 3'b101;
   localparam logic [2:0] OP_SYS    = 3'b110;
   localparam logic [2:0] OP_BEQ    = 3'b111;

   localparam logic [1:0] FN_OR      = 2'b00;
   localparam logic [1:0] FN_SETBOOL = 2'b01;
   localparam logic [1:0] FN_RSVD    = 2'b10;
   localparam logic [1:0] FN_HALT    = 2'b11;

   localparam logic [2:0] ULA_ADD  = 3'b000;
   localparam logic [2:0] ULA_SUB  = 3'b001;
   localparam logic [2:0] ULA_SLT  = 3'b010;
   localparam logic [2:0] ULA_OR   = 3'b011;
   localparam logic [2:0] ULA_PASS = 3'b100;

   localparam logic [1:0] SRC1_PC = 2'b00;
   localparam logic [1:0] SRC1_RS = 2'b10;
   localparam logic [1:0] SRC1_RD = 2'b11;

   localparam logic [1:0] SRC2_RT   = 2'b00;
   localparam logic [1:0] SRC2_ONE  = 2'b01;
   localparam logic [1:0] SRC2_IMM  = 2'b10;
   localparam logic [1:0] SRC2_ZERO = 2'b11;

   typedef enum logic [2:0] {
      IDLE, FETCH, DECODE, EXEC, MEM, WB, HALTED
   } state_t;

   typedef enum logic [3:0] {
      I_ADD, I_ADDI, I_LOAD, I_STORE, I_SLT, I_RESET,
      I_OR, I_SETBOOL, I_HALT, I_BEQ, I_ILLEGAL
   } instr_t;

   // op_hi flags any opcode bit above the three architected ones (opcode >= 8).
   function automatic instr_t classify(input logic [2:0] op, input logic op_hi,
                                       input logic [1:0] fn);
      instr_t r;
      r = I_ILLEGAL;
      if (!op_hi) begin
         case (op)
            OP_ADD:   r = I_ADD;
            OP_ADDI:  r = I_ADDI;
            OP_LOAD:  r = I_LOAD;
            OP_STORE: r = I_STORE;
            OP_SLT:   r = I_SLT;
            OP_RESET: r = I_RESET;
            OP_BEQ:   r = I_BEQ;
            default: begin
               case (fn)
                  FN_OR:      r = I_OR;
                  FN_SETBOOL: r = I_SETBOOL;
                  FN_HALT:    r = I_HALT;
                  default:    r = I_ILLEGAL;
               endcase
            end
         endcase
      end
      return r;
   endfunction

endpackage

// File: rtl/unidadecontrole_mc_if.sv
// Bundle between the control unit and the IR/memory/datapath side.
interface unidadecontrole_mc_if #(
   parameter int OPW    = 3,
   parameter int FUNCTW = 2,
   parameter int ULAOPW = 3,
   parameter int CNTW   = 16
);
   logic [OPW-1:0]    Opcode;
   logic [FUNCTW-1:0] Funct;
   logic              MemReady;
   logic              Zero;
   logic              halt;

   logic              MemRead;
   logic              MemWrite;
   logic              Load;
   logic              Beq;
   logic              Slt;
   logic              EscPC;
   logic              EscIR;
   logic              EscReg;
   logic [1:0]        ULAsrc1;
   logic [1:0]        ULAsrc2;
   logic [ULAOPW-1:0] ULAOp;
   logic              Halted;
   logic              Illegal;
   logic [CNTW-1:0]   InstrCount;

   modport master (
      input  Opcode, Funct, MemReady, Zero, halt,
      output MemRead, MemWrite, Load, Beq, Slt, EscPC, EscIR, EscReg,
             ULAsrc1, ULAsrc2, ULAOp, Halted, Illegal, InstrCount
   );

   modport slave (
      output Opcode, Funct, MemReady, Zero, halt,
      input  MemRead, MemWrite, Load, Beq, Slt, EscPC, EscIR, EscReg,
             ULAsrc1, ULAsrc2, ULAOp, Halted, Illegal, InstrCount
   );
endinterface

// File: rtl/unidadecontrole_mc_contador.sv
// Retired-instruction counter; wraps naturally at 2^CNTW.
module contador_instrucoes #(
   parameter int CNTW = 16
) (
   input  logic            clock,
   input  logic            clr_i,
   input  logic            en_i,
   output logic [CNTW-1:0] count_o
);
   logic [CNTW-1:0] count_q;

   // Clear has priority so a retire in the reset cycle is discarded.
   always_ff @(posedge clock) begin
      if (clr_i)
         count_q <= '0;
      else if (en_i)
         count_q <= count_q + CNTW'(1);
   end

   assign count_o = count_q;
endmodule

// File: rtl/unidadecontrole_mc.sv
// NRISC multicycle control unit.
// state  | meaning
// IDLE   | one idle cycle after reset
// FETCH  | instruction read, waits on MemReady, writes IR and PC+1
// DECODE | opcode/funct latched; halt and illegal resolved here
// EXEC   | ULA operation; beq retires here
// MEM    | load/store access, waits on MemReady; store retires here
// WB     | register-file write; retires
// HALTED | sticky (halt instruction) or paused (halt input)
module unidadecontrole_mc
   import nrisc_pkg::*;
#(
   parameter int OPW    = 3,
   parameter int FUNCTW = 2,
   parameter int ULAOPW = 3,
   parameter int CNTW   = 16
) (
   input  logic                 clock,
   input  logic                 reset,
   unidadecontrole_mc_if.master bus
);
   state_t            state_q, state_d;
   logic [OPW-1:0]    op_q;
   logic [FUNCTW-1:0] funct_q;
   logic              sticky_q;

   instr_t     instr_live, instr_q;
   logic       retire;
   logic       mem_read, mem_write, load_s, beq_s, slt_s;
   logic       esc_pc, esc_ir, esc_reg, halted_s, illegal_s;
   logic [1:0] src1, src2;
   logic [2:0] ula_op;
   logic [CNTW-1:0] cnt;

   // Next state and strobes from the state register and latched instruction.
   always_comb begin
      instr_live = classify(bus.Opcode[2:0], |(bus.Opcode >> 3), bus.Funct[1:0]);
      instr_q    = classify(op_q[2:0], |(op_q >> 3), funct_q[1:0]);
      state_d    = state_q;
      retire     = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      load_s     = 1'b0;
      beq_s      = 1'b0;
      slt_s      = 1'b0;
      esc_pc     = 1'b0;
      esc_ir     = 1'b0;
      esc_reg    = 1'b0;
      halted_s   = 1'b0;
      illegal_s  = 1'b0;
      src1       = SRC1_PC;
      src2       = SRC2_RT;
      ula_op     = ULA_ADD;
      case (state_q)
         IDLE: state_d = FETCH;
         FETCH: begin
            mem_read = 1'b1;
            src2     = SRC2_ONE;
            if (bus.MemReady) begin
               esc_ir  = 1'b1;
               esc_pc  = 1'b1;
               state_d = DECODE;
            end
         end
         DECODE: begin
            case (instr_live)
               I_HALT:    state_d = HALTED;
               I_ILLEGAL: begin
                  illegal_s = 1'b1;
                  retire    = 1'b1;
               end
               default:   state_d = EXEC;
            endcase
         end
         EXEC: begin
            state_d = WB;
            case (instr_q)
               I_ADD:   begin src1 = SRC1_RS; src2 = SRC2_RT; end
               I_ADDI:  begin src1 = SRC1_RS; src2 = SRC2_IMM; end
               I_LOAD, I_STORE: begin
                  src1    = SRC1_RS;
                  src2    = SRC2_IMM;
                  state_d = MEM;
               end
               I_SLT:   begin src1 = SRC1_RS; src2 = SRC2_RT; ula_op = ULA_SLT; end
               I_OR:    begin src1 = SRC1_RD; src2 = SRC2_ONE; ula_op = ULA_OR; end
               I_RESET, I_SETBOOL: begin
                  src1   = SRC1_RD;
                  src2   = SRC2_ZERO;
                  ula_op = ULA_PASS;
               end
               I_BEQ: begin
                  src1   = SRC1_RS;
                  src2   = SRC2_RT;
                  ula_op = ULA_SUB;
                  beq_s  = 1'b1;
                  esc_pc = bus.Zero;
                  retire = 1'b1;
               end
               default: ;
            endcase
         end
         MEM: begin
            if (instr_q == I_LOAD) mem_read = 1'b1;
            else                   mem_write = 1'b1;
            if (bus.MemReady) begin
               if (instr_q == I_LOAD) state_d = WB;
               else                   retire = 1'b1;
            end
         end
         WB: begin
            esc_reg = 1'b1;
            load_s  = (instr_q == I_LOAD);
            slt_s   = (instr_q == I_SLT);
            retire  = 1'b1;
         end
         HALTED: begin
            halted_s = 1'b1;
            if (!sticky_q && !bus.halt) state_d = FETCH;
         end
         default: state_d = IDLE;
      endcase
      if (retire) state_d = bus.halt ? HALTED : FETCH;
      // Keep every strobe quiet in the reset cycle so no write leaks out.
      if (reset) begin
         mem_read  = 1'b0;
         mem_write = 1'b0;
         load_s    = 1'b0;
         beq_s     = 1'b0;
         slt_s     = 1'b0;
         esc_pc    = 1'b0;
         esc_ir    = 1'b0;
         esc_reg   = 1'b0;
         halted_s  = 1'b0;
         illegal_s = 1'b0;
         src1      = 2'b00;
         src2      = 2'b00;
         ula_op    = 3'b000;
      end
   end

   // State, instruction latch and sticky-halt flag.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= IDLE;
         op_q     <= '0;
         funct_q  <= '0;
         sticky_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == DECODE) begin
            op_q    <= bus.Opcode;
            funct_q <= bus.Funct;
            if (instr_live == I_HALT) sticky_q <= 1'b1;
         end
      end
   end

   contador_instrucoes #(.CNTW(CNTW)) u_contador (
      .clock   (clock),
      .clr_i   (reset),
      .en_i    (retire),
      .count_o (cnt)
   );

   assign bus.MemRead    = mem_read;
   assign bus.MemWrite   = mem_write;
   assign bus.Load       = load_s;
   assign bus.Beq        = beq_s;
   assign bus.Slt        = slt_s;
   assign bus.EscPC      = esc_pc;
   assign bus.EscIR      = esc_ir;
   assign bus.EscReg     = esc_reg;
   assign bus.ULAsrc1    = src1;
   assign bus.ULAsrc2    = src2;
   assign bus.ULAOp      = ULAOPW'(ula_op);
   assign bus.Halted     = halted_s;
   assign bus.Illegal    = illegal_s;
   assign bus.InstrCount = reset ? '0 : cnt;
endmodule

// File: tb/tb_unidadecontrole_mc.sv
// Bench for the NRISC multicycle control unit (CNTW=4 so the counter wraps).
module tb_unidadecontrole_mc;
   localparam int CNTW = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   unidadecontrole_mc_if #(.OPW(3), .FUNCTW(2), .ULAOPW(3), .CNTW(CNTW)) bus ();

   unidadecontrole_mc #(.OPW(3), .FUNCTW(2), .ULAOPW(3), .CNTW(CNTW)) dut (
      .clock (clk),
      .reset (rst),
      .bus   (bus)
   );

   typedef struct packed {
      logic       mr, mw, ld, beq, slt, escpc, escir, escreg;
      logic [1:0] s1, s2;
      logic [2:0] op;
      logic       halted, illegal;
   } vec_t;

   int checks = 0;
   int errors = 0;
   int model_cnt = 0;

   function automatic vec_t obs_vec();
      vec_t v;
      v.mr = bus.MemRead;   v.mw = bus.MemWrite; v.ld = bus.Load;
      v.beq = bus.Beq;      v.slt = bus.Slt;     v.escpc = bus.EscPC;
      v.escir = bus.EscIR;  v.escreg = bus.EscReg;
      v.s1 = bus.ULAsrc1;   v.s2 = bus.ULAsrc2;  v.op = bus.ULAOp;
      v.halted = bus.Halted; v.illegal = bus.Illegal;
      return v;
   endfunction

   function automatic bit rb();
      return 1'($urandom);
   endfunction

   // One clock: drive inputs, compare outputs at the falling edge.
   task automatic step(input bit mr, input bit z, input bit h, input vec_t exp, input string tag);
      bus.MemReady = mr;
      bus.Zero     = z;
      bus.halt     = h;
      @(negedge clk);
      checks++;
      assert (obs_vec() === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs_vec(), exp);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_count(input string tag);
      checks++;
      assert (bus.InstrCount === CNTW'(model_cnt))
      else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, bus.InstrCount, model_cnt);
      end
   endtask

   // Instruction finished: count it, then model a pause if halt was seen at retire.
   task automatic retire_model(input bit hret);
      vec_t v;
      int k;
      model_cnt = (model_cnt + 1) % (1 << CNTW);
      check_count("count");
      if (hret) begin
         v = '0;
         v.halted = 1'b1;
         k = $urandom_range(0, 3);
         for (int i = 0; i < k; i++) step(rb(), rb(), 1'b1, v, "paused");
         step(rb(), rb(), 1'b0, v, "pause_release");
      end
   endtask

   task automatic fetch_ok();
      vec_t v;
      v = '0; v.mr = 1'b1; v.s2 = 2'b01; v.escir = 1'b1; v.escpc = 1'b1;
      step(1'b1, rb(), rb(), v, "fetch");
   endtask

   // Expected behaviour of one instruction from the instruction-set description.
   task automatic run_instr(input logic [2:0] op, input logic [1:0] fn, input int fw,
                            input int mw, input bit z, input bit hret);
      vec_t v;
      bit illegal, is_load, is_mem, is_beq;
      illegal = (op == 3'd6) && (fn == 2'd2);
      is_load = (op == 3'd2);
      is_mem  = (op == 3'd2) || (op == 3'd3);
      is_beq  = (op == 3'd7);
      bus.Opcode = op;
      bus.Funct  = fn;
      for (int i = 0; i < fw; i++) begin
         v = '0; v.mr = 1'b1; v.s2 = 2'b01;
         step(1'b0, rb(), rb(), v, "fetch_wait");
      end
      fetch_ok();
      v = '0; v.illegal = illegal;
      step(rb(), rb(), illegal ? hret : rb(), v, "decode");
      bus.Opcode = 3'($urandom);
      bus.Funct  = 2'($urandom);
      if (illegal) begin
         retire_model(hret);
         return;
      end
      v = '0;
      case (op)
         3'd0: begin v.s1 = 2'b10; v.s2 = 2'b00; v.op = 3'd0; end
         3'd1, 3'd2, 3'd3: begin v.s1 = 2'b10; v.s2 = 2'b10; v.op = 3'd0; end
         3'd4: begin v.s1 = 2'b10; v.s2 = 2'b00; v.op = 3'd2; end
         3'd5: begin v.s1 = 2'b11; v.s2 = 2'b11; v.op = 3'd4; end
         3'd6: begin
            if (fn == 2'd0) begin v.s1 = 2'b11; v.s2 = 2'b01; v.op = 3'd3; end
            else            begin v.s1 = 2'b11; v.s2 = 2'b11; v.op = 3'd4; end
         end
         default: begin v.s1 = 2'b10; v.s2 = 2'b00; v.op = 3'd1; v.beq = 1'b1; v.escpc = z; end
      endcase
      step(rb(), z, is_beq ? hret : rb(), v, "exec");
      if (is_beq) begin
         retire_model(hret);
         return;
      end
      if (is_mem) begin
         v = '0; v.mr = is_load; v.mw = !is_load;
         for (int i = 0; i < mw; i++) step(1'b0, rb(), rb(), v, "mem_wait");
         step(1'b1, rb(), is_load ? rb() : hret, v, "mem");
         if (!is_load) begin
            retire_model(hret);
            return;
         end
      end
      v = '0; v.escreg = 1'b1; v.ld = is_load; v.slt = (op == 3'd4);
      step(rb(), rb(), hret, v, "wb");
      retire_model(hret);
   endtask

   initial begin
      vec_t v;
      logic [2:0] rop;
      logic [1:0] rfn;
      bus.Opcode = '0; bus.Funct = '0; bus.MemReady = 1'b0; bus.Zero = 1'b0; bus.halt = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      step(1'b1, 1'b1, 1'b1, '0, "reset_gate");
      check_count("count_reset");
      rst = 1'b0;
      step(rb(), rb(), rb(), '0, "idle");

      run_instr(3'd0, 2'd0, 0, 0, 1'b0, 1'b0);   // add
      run_instr(3'd2, 2'd0, 0, 2, 1'b0, 1'b0);   // load, two MemReady-low cycles in MEM
      run_instr(3'd7, 2'd0, 0, 0, 1'b1, 1'b0);   // beq taken
      run_instr(3'd7, 2'd0, 0, 0, 1'b0, 1'b0);   // beq not taken
      run_instr(3'd1, 2'd0, 0, 0, 1'b0, 1'b1);   // addi, halt at retire
      run_instr(3'd6, 2'd2, 0, 0, 1'b0, 1'b0);   // reserved funct: illegal
      run_instr(3'd6, 2'd0, 1, 0, 1'b0, 1'b0);   // or, one fetch wait
      run_instr(3'd6, 2'd1, 0, 0, 1'b0, 1'b0);   // setbool
      run_instr(3'd5, 2'd0, 0, 0, 1'b0, 1'b0);   // reset rd
      run_instr(3'd4, 2'd0, 0, 0, 1'b0, 1'b0);   // slt
      run_instr(3'd3, 2'd0, 2, 1, 1'b0, 1'b0);   // store with waits
      run_instr(3'd6, 2'd2, 0, 0, 1'b0, 1'b1);   // illegal with halt at retire

      for (int i = 0; i < 16; i++) run_instr(3'd0, 2'd0, 0, 0, 1'b0, 1'b0);

      for (int i = 0; i < 40; i++) begin
         rop = 3'($urandom);
         rfn = 2'($urandom);
         if (rop == 3'd6 && rfn == 2'd3) rfn = 2'd0;
         run_instr(rop, rfn, $urandom_range(0, 2), $urandom_range(0, 2), rb(),
                   ($urandom_range(0, 3) == 0));
      end

      // Reset while a store is waiting in MEM.
      bus.Opcode = 3'd3; bus.Funct = 2'd0;
      fetch_ok();
      step(rb(), rb(), rb(), '0, "st_decode");
      v = '0; v.s1 = 2'b10; v.s2 = 2'b10;
      step(rb(), rb(), rb(), v, "st_exec");
      v = '0; v.mw = 1'b1;
      step(1'b0, rb(), rb(), v, "st_mem_wait");
      rst = 1'b1;
      step(1'b1, rb(), rb(), '0, "reset_mid_mem");
      rst = 1'b0;
      model_cnt = 0;
      check_count("count_after_abort");
      step(rb(), rb(), rb(), '0, "idle_after_abort");

      // Halt instruction: Halted from the third cycle, immune to the halt input.
      run_instr(3'd0, 2'd0, 0, 0, 1'b0, 1'b0);
      bus.Opcode = 3'd6; bus.Funct = 2'd3;
      fetch_ok();
      step(rb(), rb(), rb(), '0, "halt_decode");
      v = '0; v.halted = 1'b1;
      for (int i = 0; i < 6; i++) step(rb(), rb(), 1'(i), v, "sticky");
      check_count("count_halt_instr");
      rst = 1'b1;
      step(rb(), rb(), rb(), '0, "reset_from_halt");
      rst = 1'b0;
      model_cnt = 0;
      check_count("count_after_halt_reset");
      step(rb(), rb(), rb(), '0, "idle_after_halt");
      run_instr(3'd0, 2'd0, 0, 0, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
